sha256_compress_core: RTL and testbench

Consumes the 64-word message schedule stream (one W_t per enabled cycle, t = 0..63) from the chunk message-schedule stage and runs the 64 SHA-256 compression rounds, one round per accepted word. Maintains the running hash state H0..H7 across chunks and presents the 256-bit digest. Sits directly downstream of the schedule stage and upstream of the AXI register/readout logic.

---
 rtl/sha256_pkg.sv | 67 ++++++
 rtl/sha256_k_rom.sv | 11 +
 rtl/sha256_compress_core.sv | 142 ++++++++++++++
 tb/tb_sha256_compress_core.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash values, FSM state
// encoding and the round/schedule bit functions.
package sha256_pkg;

   typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

   localparam logic [255:0] Iv256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [255:0] Iv224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   localparam logic [31:0] KTable [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   // Message-schedule functions, used by the upstream schedule stage.
   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup: K[t] for a 6-bit round index.
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [5:0]  idx_i,
   output logic [31:0] k_o
);

   assign k_o = KTable[idx_i];

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 compression core: one round per accepted schedule word, H folded in FINAL.
// Optional SHA-224 support is enabled by defining SHA256_SHA224_EN.
module sha256_compress_core
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         start_i,
   input  logic         first_i,
   input  logic         w_vaild_i,
   input  logic [31:0]  w_i,
`ifdef SHA256_SHA224_EN
   input  logic         mode224_i,
`endif
   output logic         busy_o,
   output logic [5:0]   round_o,
   output logic         done_o,
   output logic [255:0] digest_o
);

   state_e             state_q, state_d;
   logic [5:0]         t_q, t_d;
   logic [7:0][31:0]   h_q, h_d;       // H0 in [7]
   logic [7:0][31:0]   work_q, work_d; // a in [7] .. h in [0]
   logic               done_q, done_d;
   logic [255:0]       iv_sel;
   logic [31:0]        k_t, t1, t2;
   logic [31:0]        va, vb, vc, vd, ve, vf, vg, vh;

   sha256_k_rom u_k_rom (
      .idx_i (t_q),
      .k_o   (k_t)
   );

   assign va = work_q[7];
   assign vb = work_q[6];
   assign vc = work_q[5];
   assign vd = work_q[4];
   assign ve = work_q[3];
   assign vf = work_q[2];
   assign vg = work_q[1];
   assign vh = work_q[0];

   assign t1 = vh + big_sigma1(ve) + ch(ve, vf, vg) + k_t + w_i;
   assign t2 = big_sigma0(va) + maj(va, vb, vc);

`ifdef SHA256_SHA224_EN
   logic m224_q, m224_d;

   assign iv_sel = mode224_i ? Iv224 : Iv256;

   always_comb begin
      m224_d = m224_q;
      if (clear) begin
         m224_d = 1'b0;
      end else if (state_q == StIdle && start_i && first_i) begin
         m224_d = mode224_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m224_q <= 1'b0;
      end else begin
         m224_q <= m224_d;
      end
   end

   // H7 is not part of a SHA-224 digest.
   assign digest_o = m224_q ? {h_q[7:1], 32'h0} : h_q;
`else
   assign iv_sel   = Iv256;
   assign digest_o = h_q;
`endif

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      h_d     = h_q;
      work_d  = work_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (first_i) begin
                  h_d    = iv_sel;
                  work_d = iv_sel;
               end else begin
                  work_d = h_q;
               end
               t_d     = '0;
               state_d = StRound;
            end
         end
         StRound: begin
            if (w_vaild_i) begin
               work_d = {t1 + t2, va, vb, vc, vd + t1, ve, vf, vg};
               t_d    = t_q + 6'd1;
               if (t_q == 6'd63) begin
                  state_d = StFinal;
               end
            end
         end
         StFinal: begin
            h_d = {h_q[7] + va, h_q[6] + vb, h_q[5] + vc, h_q[4] + vd,
                   h_q[3] + ve, h_q[2] + vf, h_q[1] + vg, h_q[0] + vh};
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (clear) begin
         state_d = StIdle;
         t_d     = '0;
         h_d     = '0;
         work_d  = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         t_q     <= '0;
         h_q     <= '0;
         work_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         h_q     <= h_d;
         work_q  <= work_d;
         done_q  <= done_d;
      end
   end

   assign busy_o  = (state_q == StRound) || (state_q == StFinal);
   assign round_o = t_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Self-checking bench for sha256_compress_core: a software SHA-256 model drives
// expected per-cycle outputs; known digests pin the model. Honours SHA256_SHA224_EN.
module tb_sha256_compress_core;

   localparam logic [255:0] IV256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   localparam logic [255:0] IV224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };
   localparam logic [255:0] DIG_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_EMPTY =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIG_TWO =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] DIG_224 =
      256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic         clk;
   logic         rst_n;
   logic         clear;
   logic         start_i;
   logic         first_i;
   logic         w_vaild_i;
   logic [31:0]  w_i;
`ifdef SHA256_SHA224_EN
   logic         mode224;
`endif
   logic         busy_o;
   logic [5:0]   round_o;
   logic         done_o;
   logic [255:0] digest_o;

   sha256_compress_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .start_i   (start_i),
      .first_i   (first_i),
      .w_vaild_i (w_vaild_i),
      .w_i       (w_i),
`ifdef SHA256_SHA224_EN
      .mode224_i (mode224),
`endif
      .busy_o    (busy_o),
      .round_o   (round_o),
      .done_o    (done_o),
      .digest_o  (digest_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int           checks   = 0;
   int           failures = 0;
   bit           chk_en   = 1'b0;
   logic         exp_busy = 1'b0;
   logic [5:0]   exp_round = '0;
   logic         exp_done = 1'b0;
   logic [255:0] exp_digest = '0;
   logic [255:0] mdl_h = '0;
   bit           mdl_m224 = 1'b0;
   logic [31:0]  blk [16];
   logic [31:0]  sched [64];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy_o", {255'd0, busy_o}, {255'd0, exp_busy});
         check("round_o", {250'd0, round_o}, {250'd0, exp_round});
         check("done_o", {255'd0, done_o}, {255'd0, exp_done});
         check("digest_o", digest_o, exp_digest);
      end
   end

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] fmt(input logic [255:0] h, input bit m);
      return m ? {h[255:32], 32'h0} : h;
   endfunction

   // Standard FIPS 180-4 message expansion of blk into sched.
   task automatic expand();
      for (int i = 0; i < 16; i++) sched[i] = blk[i];
      for (int i = 16; i < 64; i++) begin
         sched[i] = (rr(sched[i-2], 17) ^ rr(sched[i-2], 19) ^ (sched[i-2] >> 10))
                  + sched[i-7]
                  + (rr(sched[i-15], 7) ^ rr(sched[i-15], 18) ^ (sched[i-15] >> 3))
                  + sched[i-16];
      end
   endtask

   function automatic logic [255:0] model_compress(input logic [255:0] hin);
      logic [31:0]  hw [8];
      logic [31:0]  v [8];
      logic [31:0]  s1, s0, tt1, tt2;
      logic [255:0] res;
      for (int i = 0; i < 8; i++) begin
         hw[i] = hin[255 - 32*i -: 32];
         v[i]  = hw[i];
      end
      for (int t = 0; t < 64; t++) begin
         s1  = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
         s0  = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
         tt1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + sched[t];
         tt2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + tt1;
         v[0] = tt1 + tt2;
      end
      for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hw[i] + v[i];
      return res;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         start_i   = 1'b0;
         first_i   = 1'b0;
         w_vaild_i = 1'b1;  // words in IDLE must be dropped
         w_i       = $urandom;
         step();
         exp_done = 1'b0;
      end
   endtask

   // Drives one chunk from sched; spur_at / clr_at < 0 disable those events.
   task automatic run_chunk(input bit first, input bit m224, input int max_gap,
                            input int spur_at, input int clr_at);
      logic [255:0] fin;
      int           gap;
      start_i   = 1'b1;
      first_i   = first;
      w_vaild_i = 1'b1;
      w_i       = $urandom;
`ifdef SHA256_SHA224_EN
      mode224 = m224;
`endif
      step();
      start_i = 1'b0;
      first_i = 1'b0;
`ifdef SHA256_SHA224_EN
      mode224 = 1'b0;
      if (first) mdl_m224 = m224;
`endif
      if (first) mdl_h = mdl_m224 ? IV224 : IV256;
      fin        = model_compress(mdl_h);
      exp_busy   = 1'b1;
      exp_round  = '0;
      exp_done   = 1'b0;
      exp_digest = fmt(mdl_h, mdl_m224);
      for (int t = 0; t < 64; t++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            w_vaild_i = 1'b0;
            w_i       = $urandom;
            step();
         end
         w_vaild_i = 1'b1;
         w_i       = sched[t];
         start_i   = (t == spur_at);
         first_i   = (t == spur_at);
         clear     = (t == clr_at);
         step();
         start_i = 1'b0;
         first_i = 1'b0;
         if (t == clr_at) begin
            clear      = 1'b0;
            mdl_h      = '0;
            mdl_m224   = 1'b0;
            exp_busy   = 1'b0;
            exp_round  = '0;
            exp_digest = '0;
            return;
         end
         exp_round = 6'(t + 1);
      end
      w_vaild_i = 1'b1;  // FINAL cycle: word ignored
      w_i       = $urandom;
      step();
      mdl_h      = fin;
      exp_busy   = 1'b0;
      exp_done   = 1'b1;
      exp_digest = fmt(mdl_h, mdl_m224);
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = '0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      expand();
   endtask

   initial begin
      logic [7:0] b;
      rst_n     = 1'b1;
      clear     = 1'b0;
      start_i   = 1'b0;
      first_i   = 1'b0;
      w_vaild_i = 1'b0;
      w_i       = '0;
`ifdef SHA256_SHA224_EN
      mode224 = 1'b0;
`endif
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) step();
      check("reset_digest", digest_o, 256'd0);
      check("reset_busy", {255'd0, busy_o}, 256'd0);
      rst_n = 1'b1;
      idle(2);

      // "abc", contiguous words
      set_abc();
      run_chunk(1'b1, 1'b0, 0, -1, -1);
      @(negedge clk);
      check("abc_done", {255'd0, done_o}, 256'd1);
      check("abc_digest", digest_o, DIG_ABC);
      check("abc_model", mdl_h, DIG_ABC);
      #1;
      idle(3);

      // Empty message with random valid gaps
      for (int i = 0; i < 16; i++) blk[i] = '0;
      blk[0] = 32'h80000000;
      expand();
      run_chunk(1'b1, 1'b0, 5, -1, -1);
      @(negedge clk);
      check("empty_digest", digest_o, DIG_EMPTY);
      check("empty_model", mdl_h, DIG_EMPTY);
      #1;
      idle(2);

      // Two-block message, second chunk continues from H
      for (int i = 0; i < 14; i++) begin
         b      = 8'h61 + 8'(i);
         blk[i] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      end
      blk[14] = 32'h80000000;
      blk[15] = '0;
      expand();
      run_chunk(1'b1, 1'b0, 0, -1, -1);
      idle(1);
      for (int i = 0; i < 16; i++) blk[i] = '0;
      blk[15] = 32'h000001c0;
      expand();
      run_chunk(1'b0, 1'b0, 0, -1, -1);
      @(negedge clk);
      check("two_digest", digest_o, DIG_TWO);
      check("two_model", mdl_h, DIG_TWO);
      #1;
      idle(2);

      // Spurious start at round 30 must be ignored
      set_abc();
      run_chunk(1'b1, 1'b0, 0, 30, -1);
      @(negedge clk);
      check("spur_digest", digest_o, DIG_ABC);
      #1;
      idle(2);

      // Clear at round 40 aborts; a fresh run afterwards still works
      run_chunk(1'b1, 1'b0, 0, -1, 40);
      @(negedge clk);
      check("clear_busy", {255'd0, busy_o}, 256'd0);
      check("clear_digest", digest_o, 256'd0);
      #1;
      idle(4);
      run_chunk(1'b1, 1'b0, 2, -1, -1);
      @(negedge clk);
      check("after_clear_digest", digest_o, DIG_ABC);
      #1;
      idle(2);

`ifdef SHA256_SHA224_EN
      run_chunk(1'b1, 1'b1, 0, -1, -1);
      @(negedge clk);
      check("sha224_digest", digest_o, DIG_224);
      check("sha224_model", fmt(mdl_h, 1'b1), DIG_224);
      #1;
      idle(2);
`endif

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
